// File: rtl/core_pkg.sv
// Shared core types for the RV32 register file slice.
// Holds word/index typedefs and the x0 index constant.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int IDX_W  = 5;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [IDX_W-1:0] reg_idx_t;

  localparam int REG_ZERO = 0;

  function automatic logic is_zero_idx(
    input reg_idx_t idx
  );
    return idx == reg_idx_t'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Ports: regs_i (flattened storage), raddr_i, write-back snoop (we_i,
// waddr_i, wdata_i), byp_en_i (runtime bypass gate), rdata_o.
module regfile_read_port
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [ADDR_WIDTH-1:0]               raddr_i,
  input  logic                                we_i,
  input  logic [ADDR_WIDTH-1:0]               waddr_i,
  input  logic [DATA_WIDTH-1:0]               wdata_i,
  input  logic                                byp_en_i,
  output logic [DATA_WIDTH-1:0]               rdata_o
);

  logic                  rd_zero;
  logic                  hit;
  logic [DATA_WIDTH-1:0] stored;

  assign rd_zero = raddr_i == ADDR_WIDTH'(REG_ZERO);
  assign stored  = regs_i[raddr_i];

  // x0 never bypasses; the zero-force below covers it too.
  assign hit = BYPASS_EN && byp_en_i && we_i &&
               (waddr_i == raddr_i) && !rd_zero;

  always_comb begin
    rdata_o = stored;
    unique case (1'b1)
      rd_zero: rdata_o = '0;
      hit:     rdata_o = wdata_i;
      default: rdata_o = stored;
    endcase
  end

endmodule

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 2 combinational reads, 1 sync write.
// Ports: clk_i, reset_i (async, active-low), read_register_{1,2}_i,
// write_register_i, write_back_data_i, ctrl_write_back_i,
// register_data_{1,2}_o. x0 reads zero; write-back bypasses to reads.
module rv32_register_file
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] read_register_1_i,
  input  logic [ADDR_WIDTH-1:0] read_register_2_i,
  input  logic [ADDR_WIDTH-1:0] write_register_i,
  input  logic [DATA_WIDTH-1:0] write_back_data_i,
  input  logic                  ctrl_write_back_i,
  output logic [DATA_WIDTH-1:0] register_data_1_o,
  output logic [DATA_WIDTH-1:0] register_data_2_o
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic                                wr_en;
  logic                                byp_en;

  assign wr_en = ctrl_write_back_i &&
                 (write_register_i != ADDR_WIDTH'(REG_ZERO));

  // No forwarding while held in reset so outputs stay at zero.
  assign byp_en = reset_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      regs_q <= '0;
    end else if (wr_en) begin
      regs_q[write_register_i] <= write_back_data_i;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (BYPASS_EN)
  ) u_rp1 (
    .regs_i   (regs_q),
    .raddr_i  (read_register_1_i),
    .we_i     (ctrl_write_back_i),
    .waddr_i  (write_register_i),
    .wdata_i  (write_back_data_i),
    .byp_en_i (byp_en),
    .rdata_o  (register_data_1_o)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (BYPASS_EN)
  ) u_rp2 (
    .regs_i   (regs_q),
    .raddr_i  (read_register_2_i),
    .we_i     (ctrl_write_back_i),
    .waddr_i  (write_register_i),
    .wdata_i  (write_back_data_i),
    .byp_en_i (byp_en),
    .rdata_o  (register_data_2_o)
  );

endmodule

// File: tb/tb_rv32_register_file.sv
// Self-checking bench for rv32_register_file.
// Expected reads are queued at stimulus time and popped at sample time.
module tb_rv32_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1;
  logic [31:0] rd2;

  rv32_register_file dut (
    .clk_i             (clk),
    .reset_i           (rst_n),
    .read_register_1_i (ra1),
    .read_register_2_i (ra2),
    .write_register_i  (wa),
    .write_back_data_i (wd),
    .ctrl_write_back_i (we),
    .register_data_1_o (rd1),
    .register_data_2_o (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  logic [31:0] mdl [32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int port,
                      input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.port = port;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Let combinational reads settle, then drain the scoreboard.
  task automatic drain();
    sb_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, (e.port == 1) ? rd1 : rd2, e.exp);
    end
  endtask

  task automatic edge_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] r1,
                       input logic [4:0] r2);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  initial begin
    int idx;
    int r2;
    logic [31:0] d;

    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1 rst_n = 1'b0;
    push("rst_x1", 1, 32'h0);
    push("rst_x31", 2, 32'h0);
    drain();

    edge_step();
    rst_n = 1'b1;
    push("rel_x1", 1, 32'h0);
    drain();

    drive(1'b1, 5'd1, 32'hAABBCCDD, 5'd0, 5'd0);
    edge_step();
    drive(1'b1, 5'd2, 32'hABCDABCD, 5'd0, 5'd0);
    edge_step();
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    push("rd_x1", 1, 32'hAABBCCDD);
    push("rd_x2", 2, 32'hABCDABCD);
    drain();

    drive(1'b1, 5'd3, 32'hA0B0C0D0, 5'd3, 5'd2);
    push("byp_x3", 1, 32'hA0B0C0D0);
    push("nobyp_x2", 2, 32'hABCDABCD);
    drain();
    edge_step();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    push("post_x3_p1", 1, 32'hA0B0C0D0);
    push("post_x3_p2", 2, 32'hA0B0C0D0);
    drain();

    drive(1'b1, 5'd4, 32'h55AA33CC, 5'd4, 5'd4);
    push("dual_byp_p1", 1, 32'h55AA33CC);
    push("dual_byp_p2", 2, 32'h55AA33CC);
    drain();
    edge_step();

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    push("x0_pre_p1", 1, 32'h0);
    push("x0_pre_p2", 2, 32'h0);
    drain();
    edge_step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd4);
    push("x0_post", 1, 32'h0);
    push("x4_kept", 2, 32'h55AA33CC);
    drain();

    drive(1'b0, 5'd1, 32'h12345678, 5'd1, 5'd1);
    push("we0_nobyp", 1, 32'hAABBCCDD);
    drain();
    edge_step();
    push("we0_kept", 2, 32'hAABBCCDD);
    drain();

    drive(1'b1, 5'd31, 32'hDEADBEEF, 5'd30, 5'd31);
    push("x30_zero", 1, 32'h0);
    push("byp_x31", 2, 32'hDEADBEEF);
    drain();
    edge_step();
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    push("x31_kept", 1, 32'hDEADBEEF);
    push("x1_vs_x31", 2, 32'hAABBCCDD);
    drain();

    #2 rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    push("mid_rst_x1", 1, 32'h0);
    push("mid_rst_x2", 2, 32'h0);
    drain();
    drive(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd3);
    push("rst_nobyp", 1, 32'h0);
    push("mid_rst_x3", 2, 32'h0);
    drain();
    edge_step();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    push("rst_wr_drop", 1, 32'h0);
    push("rst_x31", 2, 32'h0);
    drain();

    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int k = 0; k < 16; k++) begin
      idx = $urandom_range(0, 31);
      r2  = $urandom_range(0, 31);
      if (k % 4 == 0) r2 = idx;
      d = $urandom;
      drive(1'b1, 5'(idx), d, 5'(idx), 5'(r2));
      push("rnd_p1", 1, (idx == 0) ? 32'h0 : d);
      push("rnd_p2", 2,
           (r2 == idx && idx != 0) ? d : mdl[r2]);
      drain();
      edge_step();
      if (idx != 0) mdl[idx] = d;
    end
    we = 1'b0;
    for (int i = 0; i < 32; i += 2) begin
      ra1 = 5'(i);
      ra2 = 5'(i + 1);
      push("rnd_rb_p1", 1, mdl[i]);
      push("rnd_rb_p2", 2, mdl[i + 1]);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_register_file.md
Name: rv32_register_file

Overview:
- RV32I integer register file for the pipelined core's decode stage: 32 general-purpose registers, two combinational read ports and one synchronous write port.
- Register x0 is hardwired to zero.
- Write-to-read bypass: a value being written back in the current cycle is visible on the read ports in that same cycle. The decode stage therefore sees write-back results without an extra forwarding path.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers, including x0.
- ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS).
- BYPASS_EN, 1, 1 = combinational write-to-read forwarding enabled; 0 = reads return stored contents only.

Ports:
- clk_i  input  1  core clock; all writes occur on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- read_register_1_i  input  ADDR_WIDTH  index for read port 1.
- read_register_2_i  input  ADDR_WIDTH  index for read port 2.
- write_register_i  input  ADDR_WIDTH  index for the write port.
- write_back_data_i  input  DATA_WIDTH  data to write.
- ctrl_write_back_i  input  1  write enable.
- register_data_1_o  output  DATA_WIDTH  read data, port 1.
- register_data_2_o  output  DATA_WIDTH  read data, port 2.

Behaviour:
- Interface: one clock, clk_i. Reset reset_i is asynchronous and active-low.
- Reset:
  - reset_i low clears registers x1..x(NUM_REGS-1) to 0 immediately, with no clock required.
  - While reset_i is low, writes are ignored and both outputs are 0.
  - Reset asserted in the middle of a write: reset wins, and the register holds 0.
- Write:
  - On the rising edge of clk_i, with reset_i high, ctrl_write_back_i = 1 and write_register_i != 0: regs[write_register_i] <= write_back_data_i.
  - Writes to x0 are discarded.
  - With ctrl_write_back_i = 0, no register changes.
- Read:
  - Purely combinational, zero latency.
  - register_data_N_o = regs[read_register_N_i].
  - Index 0 always returns 0.
- Bypass (BYPASS_EN = 1):
  - Condition: ctrl_write_back_i = 1, write_register_i = read_register_N_i and read_register_N_i != 0.
  - When the condition holds, register_data_N_o = write_back_data_i in the same cycle, before the clock edge commits the write.
  - Each port evaluates the condition independently; both ports may bypass simultaneously.
  - Bypass to x0 never occurs, so the output stays 0.
- Both read ports may address the same register and receive identical data.
- Read and write at different indices in the same cycle: the read returns the old stored value of its own register, unaffected by the write.
- No X propagation: every register has a defined value after reset.

Decomposition:
- Shared package core_pkg holds:
  - typedef word_t (logic [DATA_WIDTH-1:0])
  - typedef reg_idx_t (logic [ADDR_WIDTH-1:0])
  - localparam REG_ZERO = 0
- One sub-module, regfile_read_port, instantiated twice. It performs the indexed select from the storage array, the x0 zero-forcing and the bypass compare/mux.
- Storage and write logic stay in the top module.

Test Plan:
- Reset: drive reset_i low with no clock edge -> both outputs read 0 for indices 1 and 31. Release reset_i -> x1 still reads 0.
- Basic write/read: write x1 = 0xAABBCCDD, then x2 = 0xABCDABCD, each with ctrl_write_back_i = 1 and one clock edge. Then drop the enable and set read indices 1 and 2 -> outputs are 0xAABBCCDD and 0xABCDABCD.
- Bypass: ctrl_write_back_i = 1, write_register_i = 3, write_back_data_i = 0xA0B0C0D0, read_register_1_i = 3, before any edge -> register_data_1_o = 0xA0B0C0D0 immediately. After the edge, with the enable dropped, it still reads 0xA0B0C0D0.
- x0 protection: write 0xFFFFFFFF to x0 with the enable high -> read of x0 returns 0 both before and after the edge, and no bypass occurs.
- Enable low: ctrl_write_back_i = 0, write_register_i = 1, data 0x12345678, one clock edge -> x1 keeps 0xAABBCCDD and no bypass occurs.
- Mid-run reset: after the writes above, pulse reset_i low between clock edges -> x1, x2 and x3 read 0 immediately. A write attempted while reset is low is dropped.
